// File: rtl/datapath_memory_core_pkg.sv
// Shared definitions for the LEGv8-style datapath: control-word field
// positions, ALU/PC opcodes and the RAM window.
package datapath_memory_core_pkg;

  localparam int CW_W           = 37;
  localparam int CW_DA_LSB      = 0;
  localparam int CW_SA_LSB      = 5;
  localparam int CW_SB_LSB      = 10;
  localparam int CW_WR          = 15;
  localparam int CW_BSEL        = 16;
  localparam int CW_FS_LSB      = 17;
  localparam int CW_CO          = 22;
  localparam int CW_EN_B        = 23;
  localparam int CW_EN_ADDR_ALU = 24;
  localparam int CW_EN_ALU      = 25;
  localparam int CW_MEM_RD      = 26;
  localparam int CW_MEM_WR      = 27;
  localparam int CW_SIZE_LSB    = 28;
  localparam int CW_STATUS_LD   = 30;
  localparam int CW_PCSEL       = 31;
  localparam int CW_EN_ADDR_PC  = 32;
  localparam int CW_EN_PC       = 33;
  localparam int CW_IR_LD       = 34;
  localparam int CW_PS_LSB      = 35;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  // FS[4:2] selects the operation; FS[1:0] are the operand inverts
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_LOAD = 2'b10,
    PS_REL  = 2'b11
  } ps_e;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h0002_0000;
  localparam int          RAM_WORDS_DEF = 256;

  function automatic logic ram_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:11] == base[31:11];
  endfunction

endpackage

// File: rtl/datapath_memory_core_alu64.sv
// Combinational 64-bit ALU with {V,C,N,Z} flags; C/V only meaningful for add.
module alu64
  import datapath_memory_core_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [4:0]  i_fs,
  input  logic        i_co,
  output logic [63:0] o_y,
  output logic [3:0]  o_status
);

  logic [63:0] w_a, w_b, w_sum;
  logic        w_c, w_v, w_cf, w_vf;

  always_comb begin
    w_a = i_fs[1] ? ~i_a : i_a;
    w_b = i_fs[0] ? ~i_b : i_b;
    {w_c, w_sum} = {1'b0, w_a} + {1'b0, w_b} + {64'b0, i_co};
    w_v = (w_a[63] == w_b[63]) && (w_sum[63] != w_a[63]);
    o_y  = '0;
    w_cf = 1'b0;
    w_vf = 1'b0;
    case (alu_op_e'(i_fs[4:2]))
      OP_AND: o_y = w_a & w_b;
      OP_OR:  o_y = w_a | w_b;
      OP_ADD: begin
        o_y  = w_sum;
        w_cf = w_c;
        w_vf = w_v;
      end
      OP_XOR: o_y = w_a ^ w_b;
      // shifts take the raw A operand, amount from the (possibly inverted) B
      OP_SHL: o_y = i_a << w_b[5:0];
      OP_SHR: o_y = i_a >> w_b[5:0];
      default: o_y = '0;
    endcase
    o_status = {w_vf, w_cf, o_y[63], (o_y == 64'd0)};
  end

endmodule

// File: rtl/datapath_memory_core_regfile32x64.sv
// 32x64 register file, two combinational read ports, register 31 hard zero.
module regfile32x64 (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [4:0]       i_da,
  input  logic [4:0]       i_sa,
  input  logic [4:0]       i_sb,
  input  logic [63:0]      i_wd,
  output logic [63:0]      o_a,
  output logic [63:0]      o_b,
  output logic [7:0][15:0] o_dbg
);

  logic [63:0] r_mem [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && i_da != 5'd31) begin
      r_mem[i_da] <= i_wd;
    end
  end

  assign o_a = (i_sa == 5'd31) ? 64'd0 : r_mem[i_sa];
  assign o_b = (i_sb == 5'd31) ? 64'd0 : r_mem[i_sb];

  for (genvar g = 0; g < 8; g++) begin : g_dbg
    assign o_dbg[g] = r_mem[g][15:0];
  end

endmodule

// File: rtl/datapath_memory_core.sv
// LEGv8-style datapath: regfile, ALU, PC, IR and 2 KiB RAM around shared
// tri-state data/address buses, all steered by one 37-bit control word.
module datapath_memory_core
  import datapath_memory_core_pkg::*;
#(
  parameter int          RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF
) (
  output logic        mem_read,
  output logic        mem_write,
  input  logic [36:0] control_word,
  output logic [31:0] instruction_reg_out,
  input  logic [63:0] constant,
  input  logic        reset,
  input  logic        clock,
  inout  wire  [63:0] data,
  inout  wire  [31:0] address,
  output logic [1:0]  size,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7,
  output logic [3:0]  alu_status,
  output logic [63:0] alu_out
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [4:0]  w_da, w_sa, w_sb, w_fs;
  logic [1:0]  w_ps;
  logic        w_wr, w_bsel, w_co, w_en_b, w_en_addr_alu, w_en_alu;
  logic        w_status_ld, w_pcsel, w_en_addr_pc, w_en_pc, w_ir_ld;
  logic [63:0] w_a, w_b, w_alu_b, w_ram_q;
  logic [31:0] w_pc_inc;
  logic        w_hit;
  logic [AW-1:0]   w_ram_idx;
  logic [7:0][15:0] w_dbg;

  logic [31:0] r_pc, r_ir;
  logic [3:0]  r_status;
  logic [63:0] r_ram [RAM_WORDS];

  assign w_da          = control_word[CW_DA_LSB +: 5];
  assign w_sa          = control_word[CW_SA_LSB +: 5];
  assign w_sb          = control_word[CW_SB_LSB +: 5];
  assign w_wr          = control_word[CW_WR];
  assign w_bsel        = control_word[CW_BSEL];
  assign w_fs          = control_word[CW_FS_LSB +: 5];
  assign w_co          = control_word[CW_CO];
  assign w_en_b        = control_word[CW_EN_B];
  assign w_en_addr_alu = control_word[CW_EN_ADDR_ALU];
  assign w_en_alu      = control_word[CW_EN_ALU];
  assign mem_read      = control_word[CW_MEM_RD];
  assign mem_write     = control_word[CW_MEM_WR];
  assign size          = control_word[CW_SIZE_LSB +: 2];
  assign w_status_ld   = control_word[CW_STATUS_LD];
  assign w_pcsel       = control_word[CW_PCSEL];
  assign w_en_addr_pc  = control_word[CW_EN_ADDR_PC];
  assign w_en_pc       = control_word[CW_EN_PC];
  assign w_ir_ld       = control_word[CW_IR_LD];
  assign w_ps          = control_word[CW_PS_LSB +: 2];

  regfile32x64 u_rf (
    .clock (clock),
    .reset (reset),
    .i_we  (w_wr),
    .i_da  (w_da),
    .i_sa  (w_sa),
    .i_sb  (w_sb),
    .i_wd  (data),
    .o_a   (w_a),
    .o_b   (w_b),
    .o_dbg (w_dbg)
  );

  assign w_alu_b = w_bsel ? constant : w_b;

  alu64 u_alu (
    .i_a      (w_a),
    .i_b      (w_alu_b),
    .i_fs     (w_fs),
    .i_co     (w_co),
    .o_y      (alu_out),
    .o_status (alu_status)
  );

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_hit     = ram_hit(address, RAM_BASE);
  assign w_ram_idx = address[3 +: AW];
  assign w_ram_q   = r_ram[w_ram_idx];

  // Enables are one-hot by contract; the mux order only picks a winner when
  // the microcode is already wrong.
  assign data = w_en_alu            ? alu_out :
                w_en_b              ? w_b :
                (mem_read && w_hit) ? w_ram_q :
                w_en_pc             ? {32'b0, w_pc_inc} : 'z;

  assign address = w_en_addr_alu ? alu_out[31:0] :
                   w_en_addr_pc  ? r_pc : 'z;

  // RAM has no reset; the reset term only suppresses writes while it is held
  always_ff @(posedge clock) begin
    if (!reset && mem_write && w_hit) r_ram[w_ram_idx] <= data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else begin
      case (ps_e'(w_ps))
        PS_INC:  r_pc <= w_pc_inc;
        PS_LOAD: r_pc <= w_pcsel ? constant[31:0] : w_a[31:0];
        PS_REL:  r_pc <= r_pc + {constant[29:0], 2'b00};
        default: r_pc <= r_pc;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir     <= '0;
      r_status <= '0;
    end else begin
      if (w_ir_ld)     r_ir     <= data[31:0];
      if (w_status_ld) r_status <= alu_status;
    end
  end

  assign instruction_reg_out = r_ir;
  assign r0 = w_dbg[0];
  assign r1 = w_dbg[1];
  assign r2 = w_dbg[2];
  assign r3 = w_dbg[3];
  assign r4 = w_dbg[4];
  assign r5 = w_dbg[5];
  assign r6 = w_dbg[6];
  assign r7 = w_dbg[7];

endmodule

// File: tb/tb_datapath_memory_core.sv
// Randomized bench for datapath_memory_core against a behavioural model of
// the register file, RAM, PC and IR.
module tb_datapath_memory_core;
  import datapath_memory_core_pkg::*;

  localparam logic [31:0] BASE = 32'h0002_0000;

  typedef struct packed {
    logic [1:0] ps;
    logic       irl, epc, eap, pcsel, sl;
    logic [1:0] sz;
    logic       mw, mr, enalu, enaa, enb, co;
    logic [4:0] fs;
    logic       bsel, wr;
    logic [4:0] sb, sa, da;
  } cw_s;

  logic        clock = 1'b0;
  logic        reset;
  logic [36:0] control_word;
  logic [63:0] constant;
  wire  [63:0] data;
  wire  [31:0] address;
  logic        mem_read, mem_write;
  logic [31:0] ir;
  logic [1:0]  size;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] rv [8];
  logic [3:0]  alu_status;
  logic [63:0] alu_out;

  always #5 clock = ~clock;

  datapath_memory_core dut (
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .control_word        (control_word),
    .instruction_reg_out (ir),
    .constant            (constant),
    .reset               (reset),
    .clock               (clock),
    .data                (data),
    .address             (address),
    .size                (size),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .alu_status          (alu_status),
    .alu_out             (alu_out)
  );

  always_comb rv = '{r0, r1, r2, r3, r4, r5, r6, r7};

  // model state
  logic [63:0] m_reg [32];
  logic [63:0] m_ram [256];
  bit          m_ram_ok [256];
  int unsigned written [$];
  logic [31:0] m_pc, m_ir;
  // expectations for the current cycle and pending next-state
  logic [63:0] e_alu, e_data;
  logic [3:0]  e_st;
  logic [31:0] e_addr, n_pc;
  bit          e_dvld, e_avld, n_we, n_mw, n_irl;
  logic [4:0]  n_da;
  logic [7:0]  n_idx;

  int  n_chk = 0, n_fail = 0;
  bit  chk_on = 0;
  logic [63:0] seen_alu, seen_data;
  logic [31:0] seen_addr;
  logic [3:0]  seen_st;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_m(input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] fs, input logic co,
                                output logic [63:0] y, output logic [3:0] st);
    logic [63:0] ap, bp;
    logic [64:0] s;
    logic signed [65:0] ext;
    logic c, v;
    ap = fs[1] ? ~a : a;
    bp = fs[0] ? ~b : b;
    c = 0; v = 0;
    case (fs[4:2])
      3'd0: y = ap & bp;
      3'd1: y = ap | bp;
      3'd2: begin
        s   = {1'b0, ap} + {1'b0, bp} + {64'b0, co};
        y   = s[63:0];
        c   = s[64];
        ext = $signed({{2{ap[63]}}, ap}) + $signed({{2{bp[63]}}, bp}) + $signed({65'b0, co});
        v   = !(ext[65] == ext[64] && ext[64] == ext[63]);
      end
      3'd3: y = ap ^ bp;
      3'd4: y = a << bp[5:0];
      3'd5: y = a >> bp[5:0];
      default: y = 64'd0;
    endcase
    st = {v, c, y[63], y == 64'd0};
  endfunction

  function void eval();
    cw_s c;
    logic [63:0] a, b;
    bit hit;
    c = control_word;
    a = (c.sa == 5'd31) ? 64'd0 : m_reg[c.sa];
    b = (c.sb == 5'd31) ? 64'd0 : m_reg[c.sb];
    alu_m(a, c.bsel ? constant : b, c.fs, c.co, e_alu, e_st);
    e_avld = c.enaa || c.eap;
    e_addr = c.enaa ? e_alu[31:0] : (c.eap ? m_pc : 32'd0);
    hit    = e_avld && (e_addr[31:11] == BASE[31:11]);
    n_idx  = e_addr[10:3];
    e_dvld = 1;
    if (c.enalu)               e_data = e_alu;
    else if (c.enb)            e_data = b;
    else if (c.mr && hit)      e_data = m_ram[n_idx];
    else if (c.epc)            e_data = {32'd0, m_pc + 32'd4};
    else begin e_dvld = 0;     e_data = 64'd0; end
    n_we  = c.wr && c.da != 5'd31 && e_dvld;
    n_da  = c.da;
    n_mw  = c.mw && hit && e_dvld;
    n_irl = c.irl && e_dvld;
    case (c.ps)
      2'b01:   n_pc = m_pc + 32'd4;
      2'b10:   n_pc = c.pcsel ? constant[31:0] : a[31:0];
      2'b11:   n_pc = m_pc + (constant[31:0] * 32'd4);
      default: n_pc = m_pc;
    endcase
  endfunction

  task automatic commit();
    if (n_we) m_reg[n_da] = e_data;
    if (n_mw) begin
      m_ram[n_idx] = e_data;
      if (!m_ram_ok[n_idx]) written.push_back(n_idx);
      m_ram_ok[n_idx] = 1;
    end
    if (n_irl) m_ir = e_data[31:0];
    m_pc = n_pc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
    m_pc = 0;
    m_ir = 0;
  endtask

  // compare process: every negedge, after the driver has applied the cycle's inputs
  always @(negedge clock) begin
    #2;
    if (chk_on) begin
      cw_s c;
      c = control_word;
      chk64("alu_out", alu_out, e_alu);
      chk64("alu_status", {60'd0, alu_status}, {60'd0, e_st});
      chk64("mem_read", {63'd0, mem_read}, {63'd0, c.mr});
      chk64("mem_write", {63'd0, mem_write}, {63'd0, c.mw});
      chk64("size", {62'd0, size}, {62'd0, c.sz});
      if (e_dvld) chk64("data", data, e_data);
      if (e_avld) chk64("address", {32'd0, address}, {32'd0, e_addr});
      for (int i = 0; i < 8; i++) chk64($sformatf("r%0d", i), {48'd0, rv[i]}, {48'd0, m_reg[i][15:0]});
      chk64("ir", {32'd0, ir}, {32'd0, m_ir});
    end
  end

  task automatic cycle(input cw_s c, input logic [63:0] k);
    @(negedge clock);
    control_word = c;
    constant = k;
    eval();
    #3;
    seen_alu = alu_out; seen_st = alu_status; seen_data = data; seen_addr = address;
    @(posedge clock);
    #1;
    commit();
  endtask

  function automatic cw_s mem_cw(input bit store);
    cw_s c;
    c = '0;
    c.sa = 5'd31; c.bsel = 1; c.fs = FS_ADD; c.enaa = 1;
    if (store) begin c.enb = 1; c.mw = 1; end
    else c.mr = 1;
    return c;
  endfunction

  task automatic rand_cycle();
    cw_s c;
    logic [63:0] k;
    int kind, d, a;
    int unsigned idx;
    kind = $urandom_range(0, 9);
    if (kind == 8 && written.size() == 0) kind = 6;
    k = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) k = 64'($urandom_range(0, 70));
    c = '0;
    c.da = 5'($urandom); c.sa = 5'($urandom); c.sb = 5'($urandom);
    c.fs = 5'($urandom); c.co = 1'($urandom); c.bsel = 1'($urandom);
    c.ps = 2'($urandom); c.pcsel = 1'($urandom); c.sl = 1'($urandom); c.sz = 2'($urandom);
    if (kind <= 5) begin
      d = $urandom_range(0, 3);
      a = $urandom_range(0, 2);
      c.enalu = (d == 1); c.enb = (d == 2); c.epc = (d == 3);
      c.enaa = (a == 1);  c.eap = (a == 2);
      c.wr  = (d != 0) && 1'($urandom);
      c.irl = (d != 0) && 1'($urandom);
    end else begin
      cw_s m;
      m = mem_cw(kind <= 7);
      c.sa = m.sa; c.bsel = m.bsel; c.fs = m.fs; c.co = 0;
      c.enaa = m.enaa; c.enb = m.enb; c.mw = m.mw; c.mr = m.mr;
      if (kind <= 7) begin
        idx = $urandom_range(0, 255);
        c.wr = 1'($urandom); c.irl = 1'($urandom);
      end else if (kind == 8) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        c.wr = 1; c.irl = 1'($urandom);
      end else begin
        idx = 0;
        c.mw = 1'($urandom);
      end
      if (kind <= 8) k = {32'd0, BASE + (idx << 3) + 32'($urandom_range(0, 7))};
      else begin
        k = {32'd0, $urandom};
        if (k[31:11] == BASE[31:11]) k[20] = ~k[20];
      end
    end
    cycle(c, k);
  endtask

  task automatic mid_reset();
    cw_s c;
    int unsigned idx;
    idx = (written.size() != 0) ? written[0] : 0;
    @(negedge clock);
    c = mem_cw(1);
    c.sb = 5'd5; c.wr = 1; c.da = 5'd4; c.irl = 1; c.ps = 2'b01;
    control_word = c;
    constant = {32'd0, BASE + (idx << 3)};
    eval();
    #1;
    reset = 1;
    model_reset();
    eval();
    @(posedge clock);
    #1;
    chk64("rst_mid_r4", {48'd0, r4}, 64'd0);
    chk64("rst_mid_ir", {32'd0, ir}, 64'd0);
    @(negedge clock);
    reset = 0;
    control_word = '0;
    eval();
    if (written.size() != 0) begin
      c = mem_cw(0);
      c.da = 5'd6; c.wr = 1;
      cycle(c, {32'd0, BASE + (idx << 3)});
    end
    c = '0;
    c.eap = 1;
    cycle(c, 64'd0);
    chk64("pc_after_rst", {32'd0, seen_addr}, 64'd0);
  endtask

  initial begin
    cw_s c;
    reset = 1;
    control_word = '0;
    constant = '0;
    model_reset();
    for (int i = 0; i < 256; i++) begin m_ram[i] = 64'd0; m_ram_ok[i] = 0; end
    eval();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    for (int i = 0; i < 8; i++) chk64($sformatf("rst_r%0d", i), {48'd0, rv[i]}, 64'd0);
    chk64("rst_ir", {32'd0, ir}, 64'd0);
    reset = 0;
    eval();
    chk_on = 1;

    // OR immediate into r0
    c = '0; c.sa = 31; c.bsel = 1; c.fs = FS_OR; c.da = 0; c.wr = 1; c.enalu = 1;
    cycle(c, 64'd24);
    chk64("or_alu", seen_alu, 64'd24);
    chk64("or_r0", {48'd0, r0}, 64'h0018);

    // r1 = 0 - r0
    c = '0; c.da = 1; c.sa = 31; c.sb = 0; c.fs = FS_SUB; c.co = 1; c.wr = 1; c.enalu = 1;
    cycle(c, 64'd0);
    chk64("sub_alu", seen_alu, 64'hFFFF_FFFF_FFFF_FFE8);
    chk64("sub_flags", {60'd0, seen_st}, 64'h2);
    chk64("sub_r1", {48'd0, r1}, 64'hFFE8);

    // store r1 to RAM[3], then load it into r2
    c = mem_cw(1); c.sb = 1;
    cycle(c, 64'h2_0018);
    chk64("store_addr", {32'd0, seen_addr}, 64'h0002_0018);
    chk64("store_data", seen_data, 64'hFFFF_FFFF_FFFF_FFE8);
    c = mem_cw(0); c.da = 2; c.wr = 1;
    cycle(c, 64'h2_0018);
    chk64("load_data", seen_data, 64'hFFFF_FFFF_FFFF_FFE8);
    chk64("load_r2", {48'd0, r2}, 64'hFFE8);

    // PC increments, address and data taps, IR load
    c = '0; c.ps = 2'b01;
    repeat (3) cycle(c, 64'd0);
    c = '0; c.eap = 1;
    cycle(c, 64'd0);
    chk64("pc_addr", {32'd0, seen_addr}, 64'd12);
    c = '0; c.epc = 1; c.irl = 1;
    cycle(c, 64'd0);
    chk64("pc4_data", seen_data, 64'd16);
    chk64("ir_load", {32'd0, ir}, 64'd16);

    // writes to r31 are discarded
    c = '0; c.da = 31; c.sa = 31; c.bsel = 1; c.fs = FS_OR; c.wr = 1; c.enalu = 1;
    cycle(c, 64'h55);
    c = '0; c.sa = 31; c.sb = 31; c.fs = FS_OR;
    cycle(c, 64'd0);
    chk64("r31_zero", seen_alu, 64'd0);

    repeat (400) rand_cycle();
    mid_reset();
    repeat (200) rand_cycle();

    chk_on = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
